// File: rtl/pio_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// pio_gpio_ctrl
//   Avalon-MM GPIO port serving a group of WIDTH pins from the Nios II bus.
//   It provides an output data register with per-bit direction control and
//   atomic bit set/clear, a synchronised pin input path, sticky per-bit edge
//   capture, and a maskable level interrupt.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//               4 OUTSET, 5 OUTCLR, 6 PIN, 7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits above WIDTH-1 ignored
//   readdata    read data, combinational from address, upper bits zero
//   in_port     asynchronous pin inputs
//   out_port    output data register
//   oe          per-bit output enable (1 = drive pin)
//   irq         interrupt request, active high
// ---------------------------------------------------------------------------
module pio_gpio_ctrl #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  // Last count value before capture is enabled. The synchroniser and the
  // prev register both start at 0, so a pin that is already high at reset
  // release looks like a rising edge until it has propagated through all
  // SYNC_STAGES flops plus prev.
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wd;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [2:0]       cnt_q,  cnt_d;
  logic             armed_q, armed_d;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] edge_det;

  assign wr_en     = chipselect & ~write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Input synchroniser; prev trails the synchronised value by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    if (EDGE_TYPE == 0)      edge_det = pin_s & ~prev_q;
    else if (EDGE_TYPE == 1) edge_det = ~pin_s & prev_q;
    else                     edge_det = pin_s ^ prev_q;
  end

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_d = wdata;
        3'd1:    dir_d  = wdata;
        3'd2:    mask_d = wdata;
        3'd3:    cap_d  = cap_q & ~wdata;
        3'd4:    data_d = data_q | wdata;
        3'd5:    data_d = data_q & ~wdata;
        default: ;
      endcase
    end
    // Applied after the write-1-to-clear so a same-cycle new edge wins.
    if (armed_q) cap_d = cap_d | edge_det;
    if (!armed_q) begin
      cnt_d   = cnt_q + 3'd1;
      armed_d = (cnt_q == ARM_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[WIDTH-1:0];
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data_q;
      3'd1:    readdata[WIDTH-1:0] = dir_q;
      3'd2:    readdata[WIDTH-1:0] = mask_q;
      3'd3:    readdata[WIDTH-1:0] = cap_q;
      3'd6:    readdata[WIDTH-1:0] = pin_s;
      default: ;
    endcase
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pio_gpio_ctrl
//   Three differently parameterised GPIO instances share one Avalon bus.
//   Instance 0: WIDTH 8,  RESET_VALUE A5,        rising edge,  2 sync stages
//   Instance 1: WIDTH 32, RESET_VALUE 8000_0001, any edge,     3 sync stages
//   Instance 2: WIDTH 3,  RESET_VALUE 5,         falling edge, 4 sync stages
//   The stimulus process keeps a register-level model and a per-edge pin
//   history; each read pushes expected responses into a scoreboard queue that
//   the monitor drains when the bus presents a read cycle.
// ---------------------------------------------------------------------------
module tb_pio_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        rd_flag = 1'b0;

  logic [31:0] pin [3];
  logic [7:0]  pin0, out0, oe0;
  logic [31:0] pin1, out1, oe1;
  logic [2:0]  pin2, out2, oe2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  assign pin0 = pin[0][7:0];
  assign pin1 = pin[1];
  assign pin2 = pin[2][2:0];

  always #5 clk = ~clk;

  pio_gpio_ctrl #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(pin0),
    .out_port(out0), .oe(oe0), .irq(irq0));

  pio_gpio_ctrl #(.WIDTH(32), .RESET_VALUE(32'h8000_0001), .EDGE_TYPE(2), .SYNC_STAGES(3)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(pin1),
    .out_port(out1), .oe(oe1), .irq(irq1));

  pio_gpio_ctrl #(.WIDTH(3), .RESET_VALUE(32'h5), .EDGE_TYPE(1), .SYNC_STAGES(4)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(pin2),
    .out_port(out2), .oe(oe2), .irq(irq2));

  // ---------------- instance parameters ----------------
  function automatic int wof(int i);
    case (i) 0: return 8; 1: return 32; default: return 3; endcase
  endfunction
  function automatic int sof(int i);
    case (i) 0: return 2; 1: return 3; default: return 4; endcase
  endfunction
  function automatic int eof(int i);
    case (i) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic logic [31:0] rvof(int i);
    case (i) 0: return 32'hA5; 1: return 32'h8000_0001; default: return 32'h5; endcase
  endfunction
  function automatic logic [31:0] msk(int i);
    if (wof(i) >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << wof(i)) - 32'h1;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_data [3];
  logic [31:0] m_dir  [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_cap  [3];
  int          m_n    [3];        // clock edges since reset release
  logic [31:0] m_h    [3][8];     // pin value applied before edge e, at e%8

  // Pin value the DUT sampled at edge e; before the first edge it is 0.
  function automatic logic [31:0] pin_val(int i, int e);
    if (e <= 0) return 32'h0;
    return m_h[i][e % 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = rvof(i) & msk(i);
      m_dir[i]  = '0;
      m_mask[i] = '0;
      m_cap[i]  = '0;
      m_n[i]    = 0;
    end
  endtask

  // Effect of the coming clock edge on instance i, given the driven inputs.
  task automatic model_edge(int i);
    int n, s;
    logic [31:0] a, b, det, wd, mk;
    n  = m_n[i] + 1;
    s  = sof(i);
    mk = msk(i);
    m_h[i][n % 8] = pin[i] & mk;
    // A pin seen at edge e is in the synchroniser output after edge e+s-1,
    // so the edge decided at edge n compares samples n-s and n-s-1.
    a = pin_val(i, n - s);
    b = pin_val(i, n - s - 1);
    case (eof(i))
      0:       det = a & ~b;
      1:       det = ~a & b;
      default: det = a ^ b;
    endcase
    if (n < s + 2) det = '0;
    wd = writedata & mk;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data[i] = wd;
        3'd1: m_dir[i]  = wd;
        3'd2: m_mask[i] = wd;
        3'd3: m_cap[i]  = m_cap[i] & ~wd;
        3'd4: m_data[i] = m_data[i] | wd;
        3'd5: m_data[i] = m_data[i] & ~wd;
        default: ;
      endcase
    end
    m_cap[i] = (m_cap[i] | det) & mk;
    m_n[i]   = n;
  endtask

  function automatic logic [31:0] exp_rd(int i, logic [2:0] a);
    case (a)
      3'd0: return m_data[i];
      3'd1: return m_dir[i];
      3'd2: return m_mask[i];
      3'd3: return m_cap[i];
      3'd6: return pin_val(i, m_n[i] - sof(i) + 1);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          inst;
    logic [2:0]  addr;
    logic [31:0] rd;
    logic [31:0] outp;
    logic [31:0] oe;
    logic        irq;
  } exp_t;

  exp_t sbq [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(string nm, int inst, logic [2:0] a, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d addr%0d t=%0t: actual %h required %h", nm, inst, a, $time, act, req);
    end
  endtask

  function automatic logic [31:0] act_rd(int i);
    case (i) 0: return rd0; 1: return rd1; default: return rd2; endcase
  endfunction
  function automatic logic [31:0] act_out(int i);
    case (i) 0: return {24'h0, out0}; 1: return out1; default: return {29'h0, out2}; endcase
  endfunction
  function automatic logic [31:0] act_oe(int i);
    case (i) 0: return {24'h0, oe0}; 1: return oe1; default: return {29'h0, oe2}; endcase
  endfunction
  function automatic logic act_irq(int i);
    case (i) 0: return irq0; 1: return irq1; default: return irq2; endcase
  endfunction

  always @(negedge clk) begin
    if (rd_flag) begin
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        if (sbq.size() == 0) begin
          chk("scoreboard_empty", k, address, 32'h1, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("readdata", e.inst, e.addr, act_rd(e.inst), e.rd);
          chk("out_port", e.inst, e.addr, act_out(e.inst), e.outp);
          chk("oe",       e.inst, e.addr, act_oe(e.inst), e.oe);
          chk("irq",      e.inst, e.addr, {31'h0, act_irq(e.inst)}, {31'h0, e.irq});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    if (reset_n) for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(logic [2:0] a, logic [31:0] d, logic cs = 1'b1);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(logic [2:0] a);
    exp_t e;
    address = a; chipselect = 1'b1; write_n = 1'b1; rd_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.inst = i;
      e.addr = a;
      e.rd   = exp_rd(i, a);
      e.outp = m_data[i];
      e.oe   = m_dir[i];
      e.irq  = |(m_cap[i] & m_mask[i]);
      sbq.push_back(e);
    end
    tick();
    chipselect = 1'b0; rd_flag = 1'b0;
  endtask

  task automatic idle(int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  task automatic set_pins_bit(int b, logic v);
    for (int i = 0; i < 3; i++) pin[i][b] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) pin[i] = '0;
    model_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    idle(2);
    reset_n = 1'b1;

    // Reset values on all readable registers.
    for (int a = 0; a < 8; a++) do_read(3'(a));

    // Output register writes with atomic set/clear.
    do_write(3'd0, 32'h0F);          do_read(3'd0);
    do_write(3'd4, 32'h30);          do_read(3'd4); do_read(3'd0);
    do_write(3'd5, 32'h03);          do_read(3'd5); do_read(3'd0);
    do_write(3'd1, 32'hFFFF_00C3);   do_read(3'd1);

    // Edge capture on bit 0, observed cycle by cycle.
    do_write(3'd2, 32'h8000_0001);
    idle(6);
    set_pins_bit(0, 1'b1);
    for (int j = 0; j < 3; j++) do_read(3'd6);
    for (int j = 0; j < 3; j++) do_read(3'd3);
    set_pins_bit(0, 1'b0);
    for (int j = 0; j < 6; j++) do_read(3'd3);

    // Write-1-to-clear, then a clear colliding with a fresh rising edge.
    do_write(3'd3, 32'hFFFF_FFFF);
    do_read(3'd3); do_read(3'd3);
    idle(6);
    set_pins_bit(0, 1'b1);
    tick(); tick();
    do_write(3'd3, 32'h1);
    do_read(3'd3); do_read(3'd3);

    // Asynchronous reset in the middle of a pending capture.
    set_pins_bit(1, 1'b1);
    tick();
    reset_n = 1'b0;
    model_reset();
    do_read(3'd3); do_read(3'd0);

    // Pins held high through reset release must not be captured.
    for (int i = 0; i < 3; i++) pin[i] = 32'hFFFF_FFFF;
    idle(1);
    reset_n = 1'b1;
    do_write(3'd2, 32'hFFFF_FFFF);
    for (int j = 0; j < 10; j++) begin do_read(3'd3); do_read(3'd6); end

    // Bit 31 of the 32-bit any-edge instance toggled twice, cleared between.
    do_write(3'd3, 32'hFFFF_FFFF);
    pin[1][31] = 1'b0;
    idle(6); do_read(3'd3);
    do_write(3'd3, 32'hFFFF_FFFF); do_read(3'd3);
    pin[1][31] = 1'b1;
    idle(6); do_read(3'd3);

    // Randomised traffic: writes (some without chipselect), reads, pin
    // toggles and occasional resets.
    for (int it = 0; it < 500; it++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) == 0)
          pin[i] = pin[i] ^ (32'h1 << $urandom_range(0, wof(i) - 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_read(3'($urandom_range(0, 7)));
        4, 5, 6:    do_write(3'($urandom_range(0, 7)), $urandom());
        7:          do_write(3'($urandom_range(0, 7)), $urandom(), 1'b0);
        8:          tick();
        default: begin
          if ($urandom_range(0, 15) == 0) begin
            reset_n = 1'b0;
            model_reset();
            tick();
            reset_n = 1'b1;
          end else begin
            do_read(3'd3);
          end
        end
      endcase
    end

    tick(); tick();
    chk("scoreboard_drained", 0, 3'd0, 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
